// File: rtl/bkm_iter_ctrl_pkg.sv
// Shared types and constants for the BKM iteration controller.
// Holds the FSM state encoding, the E/L mode constants and the counter widths.
package bkm_iter_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_STEP = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } bkm_state_e;

   localparam logic MODE_E = 1'b0;
   localparam logic MODE_L = 1'b1;

   localparam int N_W    = 8;
   localparam int WAIT_W = 2;

   // STEP already spends one cycle of the datapath latency, so WAIT covers PIPE-1
   // cycles and the counter runs from PIPE-2 down to zero.
   function automatic logic [WAIT_W-1:0] wait_init(input int pipe);
      return (pipe > 1) ? WAIT_W'(pipe - 2) : '0;
   endfunction

endpackage

// File: rtl/bkm_iter_cnt.sv
// Iteration index counter and WAIT down-counter for the BKM controller.
// Both saturate at their terminal count so n never passes N_ITER-1 and WAIT never wraps.
module bkm_iter_cnt
   import bkm_iter_ctrl_pkg::*;
#(
   parameter int N_ITER = 64,
   parameter int PIPE   = 1
) (
   input  logic           clk,
   input  logic           arst,
   input  logic           srst,
   input  logic           enable,
   input  logic           clr_n,
   input  logic           inc_n,
   input  logic           ld_wait,
   input  logic           dec_wait,
   output logic [N_W-1:0] n,
   output logic           n_last,
   output logic           wait_tc
);

   localparam logic [N_W-1:0]    N_MAX     = N_W'(N_ITER - 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = wait_init(PIPE);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         n <= '0;
      end else if (srst) begin
         n <= '0;
      end else if (enable) begin
         if (clr_n)
            n <= '0;
         else if (inc_n && !n_last)
            n <= n + N_W'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wait_cnt <= '0;
      end else if (srst) begin
         wait_cnt <= '0;
      end else if (enable) begin
         if (ld_wait)
            wait_cnt <= WAIT_INIT;
         else if (dec_wait && !wait_tc)
            wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end

   assign n_last  = (n == N_MAX);
   assign wait_tc = (wait_cnt == '0);

endmodule

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration sequencer: loads the datapath, strobes N_ITER steps spaced PIPE cycles
// apart, feeds the control digits back and reports done/aborted.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | load strobe, index and digits cleared
// STEP  | step strobe, digits captured from the datapath
// WAIT  | remaining PIPE-1 cycles of datapath latency
// DONE  | one-cycle completion pulse
module bkm_iter_ctrl
   import bkm_iter_ctrl_pkg::*;
#(
   parameter int W      = 64,
   parameter int N_ITER = 64,
   parameter int PIPE   = 1
) (
   input  logic           clk,
   input  logic           arst,
   input  logic           srst,
   input  logic           enable,
   input  logic           start,
   input  logic           mode,
   input  logic           abort,
   input  logic [W/4-1:0] u_np1,
   input  logic [W/4-1:0] v_np1,
   output logic           load,
   output logic           step,
   output logic [7:0]     n,
   output logic           mode_q,
   output logic [W/4-1:0] u_q,
   output logic [W/4-1:0] v_q,
   output logic           busy,
   output logic           done,
   output logic           aborted
);

   localparam bit HAS_WAIT = (PIPE > 1);

   bkm_state_e state, state_nxt;

   logic load_nxt, step_nxt, done_nxt, aborted_nxt, busy_nxt;
   logic clr_n, inc_n, ld_wait, dec_wait, take_start, cap_uv;
   logic n_last, wait_tc;

   bkm_iter_cnt #(
      .N_ITER (N_ITER),
      .PIPE   (PIPE)
   ) u_cnt (
      .clk      (clk),
      .arst     (arst),
      .srst     (srst),
      .enable   (enable),
      .clr_n    (clr_n),
      .inc_n    (inc_n),
      .ld_wait  (ld_wait),
      .dec_wait (dec_wait),
      .n        (n),
      .n_last   (n_last),
      .wait_tc  (wait_tc)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         state <= ST_IDLE;
      else if (srst)
         state <= ST_IDLE;
      else if (enable)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      clr_n       = 1'b0;
      inc_n       = 1'b0;
      ld_wait     = 1'b0;
      dec_wait    = 1'b0;
      take_start  = 1'b0;
      cap_uv      = 1'b0;
      aborted_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt  = ST_LOAD;
               take_start = 1'b1;
               clr_n      = 1'b1;
            end
         end
         ST_LOAD: begin
            state_nxt = ST_STEP;
         end
         ST_STEP: begin
            cap_uv = 1'b1;
            if (HAS_WAIT) begin
               state_nxt = ST_WAIT;
               ld_wait   = 1'b1;
            end else if (n_last) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_STEP;
               inc_n     = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!wait_tc) begin
               dec_wait = 1'b1;
            end else if (n_last) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_STEP;
               inc_n     = 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including the digit capture of a cancelled step.
      if (abort && (state != ST_IDLE)) begin
         state_nxt   = ST_IDLE;
         inc_n       = 1'b0;
         ld_wait     = 1'b0;
         dec_wait    = 1'b0;
         cap_uv      = 1'b0;
         aborted_nxt = 1'b1;
      end

      load_nxt = (state_nxt == ST_LOAD);
      step_nxt = (state_nxt == ST_STEP);
      done_nxt = (state_nxt == ST_DONE);
      busy_nxt = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         load    <= 1'b0;
         step    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         busy    <= 1'b0;
         mode_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
      end else if (srst) begin
         load    <= 1'b0;
         step    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         busy    <= 1'b0;
         mode_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
      end else if (enable) begin
         load    <= load_nxt;
         step    <= step_nxt;
         done    <= done_nxt;
         aborted <= aborted_nxt;
         busy    <= busy_nxt;
         if (take_start)
            mode_q <= mode;
         if (take_start) begin
            u_q <= '0;
            v_q <= '0;
         end else if (cap_uv) begin
            u_q <= u_np1;
            v_q <= v_np1;
         end
      end
   end

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Bench for bkm_iter_ctrl: one PIPE=1 and one PIPE=3 instance, N_ITER=4, 16-bit digits.
// Expected completions are queued at start and retired when done pulses.
module tb_bkm_iter_ctrl;

   localparam int W  = 64;
   localparam int N  = 4;
   localparam int DW = W / 4;

   logic clk = 1'b0;
   logic arst, srst, enable, start1, start3, mode, abort;
   logic [DW-1:0] u_np1, v_np1;

   logic load1, step1, busy1, done1, aborted1, mode_q1;
   logic [7:0] n1;
   logic [DW-1:0] u_q1, v_q1;
   logic load3, step3, busy3, done3, aborted3, mode_q3;
   logic [7:0] n3;
   logic [DW-1:0] u_q3, v_q3;

   typedef struct {
      int   lat;
      logic mode;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bkm_iter_ctrl #(.W(W), .N_ITER(N), .PIPE(1)) dut1 (
      .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start1),
      .mode(mode), .abort(abort), .u_np1(u_np1), .v_np1(v_np1),
      .load(load1), .step(step1), .n(n1), .mode_q(mode_q1), .u_q(u_q1), .v_q(v_q1),
      .busy(busy1), .done(done1), .aborted(aborted1)
   );

   bkm_iter_ctrl #(.W(W), .N_ITER(N), .PIPE(3)) dut3 (
      .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start3),
      .mode(mode), .abort(abort), .u_np1(u_np1), .v_np1(v_np1),
      .load(load3), .step(step3), .n(n3), .mode_q(mode_q3), .u_q(u_q3), .v_q(v_q3),
      .busy(busy3), .done(done3), .aborted(aborted3)
   );

   task automatic test_reset();
      bit stray = 1'b0;
      arst = 1'b1; srst = 1'b0; enable = 1'b1; start1 = 1'b0; start3 = 1'b0;
      mode = 1'b0; abort = 1'b0; u_np1 = '0; v_np1 = '0;
      #12;
      checks++;
      if ({load1, step1, busy1, done1, aborted1, mode_q1} !== 6'b0) begin
         errors++; $display("FAIL reset_flags1: got %b expected 000000", {load1, step1, busy1, done1, aborted1, mode_q1});
      end
      checks++;
      if ({n1, u_q1, v_q1} !== 40'h0) begin
         errors++; $display("FAIL reset_data1: got %h expected 0", {n1, u_q1, v_q1});
      end
      checks++;
      if ({load3, step3, busy3, done3, aborted3, mode_q3, n3, u_q3, v_q3} !== 46'h0) begin
         errors++; $display("FAIL reset_all3: got %h expected 0", {load3, step3, busy3, done3, aborted3, mode_q3, n3, u_q3, v_q3});
      end
      @(negedge clk); arst = 1'b0;
      // synchronous reset mid-operation
      @(negedge clk); start1 = 1'b1; mode = 1'b1;
      @(negedge clk); start1 = 1'b0;
      checks++;
      if (load1 !== 1'b1 || mode_q1 !== 1'b1) begin
         errors++; $display("FAIL srst_pre_load: got load=%b mode_q=%b expected 1 1", load1, mode_q1);
      end
      @(negedge clk); srst = 1'b1;
      @(negedge clk); srst = 1'b0;
      checks++;
      if ({busy1, step1, mode_q1, n1} !== 11'h0) begin
         errors++; $display("FAIL srst_clear: got busy=%b step=%b mode_q=%b n=%0d expected all 0", busy1, step1, mode_q1, n1);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done1 || aborted1 || busy1) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0) begin
         errors++; $display("FAIL srst_silent: got stray pulse/busy=%b expected 0", stray);
      end
   endtask

   task automatic test_pipe1_digits();
      int steps = 0;
      int dones = 0;
      exp_t e;
      @(negedge clk); start1 = 1'b1; mode = 1'b1; u_np1 = 16'h0001; v_np1 = 16'h0002;
      sb.push_back('{lat: 2 + N * 1, mode: 1'b1});
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); start1 = 1'b0;
         checks++;
         if (load1 !== (c == 1)) begin
            errors++; $display("FAIL p1_load c%0d: got %b expected %b", c, load1, (c == 1));
         end
         checks++;
         if (step1 !== (c >= 2 && c <= 5)) begin
            errors++; $display("FAIL p1_step c%0d: got %b expected %b", c, step1, (c >= 2 && c <= 5));
         end
         if (step1) begin
            steps++;
            checks++;
            if (n1 !== 8'(steps - 1)) begin
               errors++; $display("FAIL p1_n c%0d: got %0d expected %0d", c, n1, steps - 1);
            end
         end
         if (c == 4) begin
            checks++;
            if (u_q1 !== 16'hA5A5 || v_q1 !== 16'h0F0F) begin
               errors++; $display("FAIL p1_digits: got u=%h v=%h expected a5a5 0f0f", u_q1, v_q1);
            end
         end
         if (done1) begin
            dones++;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL p1_sb_empty: got done at c%0d expected none", c);
            end else begin
               e = sb.pop_front();
               checks++;
               if (c !== e.lat) begin
                  errors++; $display("FAIL p1_latency: got %0d expected %0d", c, e.lat);
               end
               checks++;
               if (mode_q1 !== e.mode) begin
                  errors++; $display("FAIL p1_mode_q: got %b expected %b", mode_q1, e.mode);
               end
            end
         end
         u_np1 = (c == 3) ? 16'hA5A5 : 16'(16'h1000 + c);
         v_np1 = (c == 3) ? 16'h0F0F : 16'(16'h2000 + c);
      end
      checks++;
      if (steps !== N || dones !== 1) begin
         errors++; $display("FAIL p1_counts: got steps=%0d dones=%0d expected %0d 1", steps, dones, N);
      end
      checks++;
      if (n1 !== 8'(N - 1) || u_q1 !== 16'h1005 || v_q1 !== 16'h2005 || busy1 !== 1'b0) begin
         errors++; $display("FAIL p1_hold: got n=%0d u=%h v=%h busy=%b expected 3 1005 2005 0", n1, u_q1, v_q1, busy1);
      end
   endtask

   task automatic test_pipe3();
      int steps = 0;
      bit got_done = 1'b0;
      bit exp_step;
      exp_t e;
      @(negedge clk); start3 = 1'b1; mode = 1'b0;
      sb.push_back('{lat: 2 + N * 3, mode: 1'b0});
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk); start3 = 1'b0;
         exp_step = (c >= 2 && c < 2 + N * 3 && (c - 2) % 3 == 0);
         checks++;
         if (step3 !== exp_step) begin
            errors++; $display("FAIL p3_step c%0d: got %b expected %b", c, step3, exp_step);
         end
         if (step3) steps++;
         checks++;
         if (busy3 !== (c <= 2 + N * 3)) begin
            errors++; $display("FAIL p3_busy c%0d: got %b expected %b", c, busy3, (c <= 2 + N * 3));
         end
         if (c == 4 || c == 6 || c == 13) begin
            checks++;
            if (n3 !== 8'((c - 2) / 3)) begin
               errors++; $display("FAIL p3_n c%0d: got %0d expected %0d", c, n3, (c - 2) / 3);
            end
         end
         if (done3) begin
            got_done = 1'b1;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL p3_sb_empty: got done at c%0d expected none", c);
            end else begin
               e = sb.pop_front();
               checks++;
               if (c !== e.lat || mode_q3 !== e.mode) begin
                  errors++; $display("FAIL p3_done: got c=%0d mode_q=%b expected %0d %b", c, mode_q3, e.lat, e.mode);
               end
            end
         end
      end
      checks++;
      if (steps !== N || !got_done) begin
         errors++; $display("FAIL p3_counts: got steps=%0d done=%b expected %0d 1", steps, got_done, N);
      end
   endtask

   task automatic test_abort();
      bit stray_done = 1'b0;
      bit got_done = 1'b0;
      exp_t e;
      @(negedge clk); start1 = 1'b1; mode = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); start1 = 1'b0; abort = 1'b0;
         if (c == 4) begin
            checks++;
            if (n1 !== 8'd2 || step1 !== 1'b1) begin
               errors++; $display("FAIL abort_pre: got n=%0d step=%b expected 2 1", n1, step1);
            end
            abort = 1'b1;
         end
         if (c == 5) begin
            checks++;
            if ({busy1, aborted1, step1, done1} !== 4'b0100) begin
               errors++; $display("FAIL abort_taken: got busy/aborted/step/done=%b expected 0100", {busy1, aborted1, step1, done1});
            end
         end
         if (c == 6) begin
            checks++;
            if (aborted1 !== 1'b0) begin
               errors++; $display("FAIL abort_pulse: got %b expected 0", aborted1);
            end
         end
         if (done1) stray_done = 1'b1;
      end
      checks++;
      if (stray_done !== 1'b0) begin
         errors++; $display("FAIL abort_no_done: got %b expected 0", stray_done);
      end
      // abort ignored in IDLE, start in same cycle wins
      @(negedge clk); start1 = 1'b1; abort = 1'b1; mode = 1'b1;
      sb.push_back('{lat: 2 + N * 1, mode: 1'b1});
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); start1 = 1'b0; abort = 1'b0;
         if (c == 1) begin
            checks++;
            if (load1 !== 1'b1 || aborted1 !== 1'b0) begin
               errors++; $display("FAIL abort_idle: got load=%b aborted=%b expected 1 0", load1, aborted1);
            end
         end
         if (done1) begin
            got_done = 1'b1;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL abort_sb_empty: got done at c%0d expected none", c);
            end else begin
               e = sb.pop_front();
               checks++;
               if (c !== e.lat || mode_q1 !== e.mode) begin
                  errors++; $display("FAIL abort_restart: got c=%0d mode_q=%b expected %0d %b", c, mode_q1, e.lat, e.mode);
               end
            end
         end
      end
      checks++;
      if (!got_done) begin
         errors++; $display("FAIL abort_restart_timeout: got no done expected done");
      end
   endtask

   task automatic test_stall_repeat();
      int steps = 0;
      int loads = 0;
      int dones = 0;
      exp_t e;
      @(negedge clk); start1 = 1'b1; mode = 1'b1;
      sb.push_back('{lat: 2 + N * 1 + 5, mode: 1'b1});
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start1 = (c <= 4);
         enable = !(c >= 3 && c <= 7);
         if (c >= 4 && c <= 8) begin
            checks++;
            if (step1 !== 1'b1 || n1 !== 8'd1) begin
               errors++; $display("FAIL stall_hold c%0d: got step=%b n=%0d expected 1 1", c, step1, n1);
            end
         end
         if (step1 && enable) steps++;
         if (load1) loads++;
         if (done1) begin
            dones++;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL stall_sb_empty: got done at c%0d expected none", c);
            end else begin
               e = sb.pop_front();
               checks++;
               if (c !== e.lat) begin
                  errors++; $display("FAIL stall_latency: got %0d expected %0d", c, e.lat);
               end
            end
         end
      end
      enable = 1'b1; start1 = 1'b0;
      checks++;
      if (steps !== N || loads !== 1 || dones !== 1) begin
         errors++; $display("FAIL stall_counts: got steps=%0d loads=%0d dones=%0d expected %0d 1 1", steps, loads, dones, N);
      end
   endtask

   task automatic test_arst_mid();
      bit stray = 1'b0;
      int steps = 0;
      bit got_done = 1'b0;
      exp_t e;
      @(negedge clk); start3 = 1'b1; mode = 1'b1; u_np1 = 16'hBEEF; v_np1 = 16'hCAFE;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); start3 = 1'b0;
      end
      checks++;
      if (step3 !== 1'b1 || n3 !== 8'd1 || u_q3 !== 16'hBEEF || mode_q3 !== 1'b1) begin
         errors++; $display("FAIL arst_pre: got step=%b n=%0d u=%h mode_q=%b expected 1 1 beef 1", step3, n3, u_q3, mode_q3);
      end
      arst = 1'b1;
      #1;
      checks++;
      if ({load3, step3, busy3, done3, aborted3, mode_q3, n3, u_q3, v_q3} !== 46'h0) begin
         errors++; $display("FAIL arst_async: got %h expected 0", {load3, step3, busy3, done3, aborted3, mode_q3, n3, u_q3, v_q3});
      end
      @(negedge clk); arst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done3 || aborted3 || busy3) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0) begin
         errors++; $display("FAIL arst_silent: got %b expected 0", stray);
      end
      @(negedge clk); start3 = 1'b1; mode = 1'b0;
      sb.push_back('{lat: 2 + N * 3, mode: 1'b0});
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk); start3 = 1'b0;
         if (step3) steps++;
         if (done3) begin
            got_done = 1'b1;
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL arst_sb_empty: got done at c%0d expected none", c);
            end else begin
               e = sb.pop_front();
               checks++;
               if (c !== e.lat || mode_q3 !== e.mode) begin
                  errors++; $display("FAIL arst_rerun: got c=%0d mode_q=%b expected %0d %b", c, mode_q3, e.lat, e.mode);
               end
            end
         end
      end
      checks++;
      if (steps !== N || !got_done) begin
         errors++; $display("FAIL arst_rerun_counts: got steps=%0d done=%b expected %0d 1", steps, got_done, N);
      end
   endtask

   initial begin
      test_reset();
      test_pipe1_digits();
      test_pipe3();
      test_abort();
      test_stall_repeat();
      test_arst_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bkm_iter_ctrl.md
BKM_ITER_CTRL -- requirements
Module: bkm_iter_ctrl

Interface
REQ-001 Parameter W, default 64: datapath word width; digit buses are W/4 bits.
REQ-002 Parameter N_ITER, default 64: BKM iterations per operation, 2..255.
REQ-003 Parameter PIPE, default 1: datapath latency per iteration in cycles, 1..4.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 arst  in  1  reset, asynchronous, active-high.
REQ-006 srst  in  1  synchronous reset, active-high; same reset values as arst.
REQ-007 enable  in  1  global clock enable; 0 freezes all state and outputs.
REQ-008 start  in  1  request a new operation; sampled only in IDLE.
REQ-009 mode  in  1  0 = E-mode, 1 = L-mode; sampled with accepted start.
REQ-010 abort  in  1  cancel the operation in progress.
REQ-011 u_np1  in  W/4  u digit from the control-step datapath.
REQ-012 v_np1  in  W/4  v digit from the control-step datapath.
REQ-013 load  out  1  one-cycle strobe loading the datapath operands.
REQ-014 step  out  1  one-cycle strobe advancing the datapath one iteration.
REQ-015 n  out  8  current iteration index.
REQ-016 mode_q  out  1  latched mode.
REQ-017 u_q, v_q  out  W/4 each  registered digits fed back to the datapath.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse when the operation completes.
REQ-020 aborted  out  1  one-cycle pulse when an abort is taken.

Function
REQ-021 FSM states are IDLE, LOAD, STEP, WAIT and DONE; all outputs are registered.
REQ-022 IDLE goes to LOAD when start=1; mode is latched into mode_q on that edge.
REQ-023 LOAD lasts one cycle with load=1; n, u_q and v_q clear to 0; next state is STEP.
REQ-024 STEP lasts one cycle with step=1; u_q<=u_np1 and v_q<=v_np1 on that edge.
REQ-025 After STEP, next state is WAIT if PIPE>1, otherwise STEP or DONE.
REQ-026 WAIT holds for PIPE-1 cycles via a down-counter, then goes to STEP or DONE.
REQ-027 n increments when leaving STEP or WAIT towards STEP; DONE is entered when n=N_ITER-1 completes.
REQ-028 step strobes per operation = N_ITER exactly; total latency from start to done = 2 + N_ITER*PIPE cycles.
REQ-029 DONE lasts one cycle with done=1, then returns to IDLE; n and digits hold until the next LOAD.
REQ-030 start while busy=1 is ignored (no queueing).
REQ-031 abort=1 in any non-IDLE state wins over every other transition: next state is IDLE, aborted=1 for one cycle, done stays 0.
REQ-032 abort in IDLE is ignored; abort and start in the same IDLE cycle starts the operation.
REQ-033 enable=0 stalls the FSM, counters and strobes; an in-flight strobe is held, not repeated.
REQ-034 n never exceeds N_ITER-1; the WAIT counter never underflows.

Reset
REQ-035 On arst (immediate) or srst (next edge), state=IDLE and all outputs=0, including n, u_q, v_q, mode_q and both pulses.
REQ-036 Reset mid-operation discards the operation silently: no done and no aborted pulse.

Structure
REQ-037 The FSM state encoding and the E/L mode constants belong in the shared bkm package.
REQ-038 One sub-module, bkm_iter_cnt, holds the iteration counter and the WAIT counter with their terminal-count flags.

Verification
REQ-039 PIPE=1, N_ITER=4, start, mode=1 -> load at cycle 1, step at cycles 2-5, done at cycle 6, mode_q=1.
REQ-040 PIPE=3, N_ITER=4 -> step every 3 cycles, 4 steps, done 14 cycles after start.
REQ-041 u_np1=16'hA5A5 and v_np1=16'h0F0F presented at the 2nd step -> u_q/v_q take those values on that edge.
REQ-042 abort at n=2 -> next cycle IDLE, aborted=1, no done; a new start is then accepted normally.
REQ-043 start repeated while busy, plus enable=0 for 5 cycles mid-run -> one operation only, done delayed by 5 cycles.
REQ-044 arst asserted mid-STEP -> outputs 0 immediately; after release, start runs a full clean operation.
